intc_ctrl: RTL
==============

# intc_ctrl

Interrupt controller that receives the level interrupt lines (`tim_int` and peers) from timer-class peripherals and presents one prioritized request to the CPU. The CPU takes a source with a claim/complete handshake. It sits between the peripheral interrupt outputs and the core's external-interrupt input. Each source is tracked by a gateway state machine, so a source is never re-presented while it is in service.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources; legal range 2..32.
- `ID_W`, default 3: width of the source index; must equal clog2(`NUM_SRC`).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `irq_in` input `NUM_SRC`: interrupt lines, active-high; bit i is source i.
- `irq_en` input `NUM_SRC`: per-source enable mask.
- `claim_req` input 1: CPU claim pulse; sampled at each edge.
- `complete` input 1: CPU completion pulse for the currently claimed source.
- `cpu_irq` output 1: request to the CPU.
- `claim_vld` output 1: `claim_id` is valid and a source is in service.
- `claim_id` output `ID_W`: index of the source in service.
- `pend_st` output `NUM_SRC`: per-source pending status.

## Operation
- Gateway per source, with states IDLE, PEND and CLAIMED.
  - IDLE to PEND on a trigger event (see Configuration).
  - PEND to CLAIMED when the source wins a claim.
  - CLAIMED to IDLE on `complete`.
  - Trigger events in PEND or CLAIMED are ignored.
- Pending is independent of enable, the same way timer `int_st` is independent of `int_en`.
  - `pend_st[i]` = gateway i is in PEND.
  - Clearing `irq_en[i]` keeps the source pending but masks it.
- Controller FSM, with states READY and BUSY.
  - `cpu_irq` = READY & |(`pend_st` & `irq_en`). This is combinational from registered state.
  - `claim_req` in READY with `cpu_irq`=1 selects the winner, loads `claim_id`, sets `claim_vld`, moves that gateway to CLAIMED and moves the controller to BUSY.
  - `complete` in BUSY returns the claimed gateway to IDLE, clears `claim_vld` and moves the controller to READY. `claim_id` holds its last value.
- Priority is fixed: the lowest enabled pending index wins.
- Ignored inputs:
  - `claim_req` in READY while `cpu_irq`=0.
  - `claim_req` in BUSY.
  - `complete` in READY.
- Only one source is in service at a time. `cpu_irq` is 0 throughout BUSY.

## Timing
- Reset value of every output is 0: `cpu_irq`, `claim_vld`, `claim_id`, `pend_st`. All gateways reset to IDLE and the controller to READY.
- Trigger sampled at edge k: `pend_st` and `cpu_irq` are high after edge k.
- `claim_req` at edge k: `claim_vld` and `claim_id` are valid after edge k, and `cpu_irq` is low after edge k.
- `complete` at edge k: `claim_vld` is low after edge k.
  - Gateway is IDLE after edge k.
  - Earliest re-trigger of the same source is at edge k+1.
  - Another pending source raises `cpu_irq` after edge k.
- `claim_req` and `complete` together in BUSY: `complete` is taken and the claim is dropped. The CPU must re-claim.
- Trigger and claim at the same edge for a source that was IDLE: the source goes to PEND. It is not eligible for that claim.
- Reset asserted mid-service: everything returns to IDLE/READY immediately. The in-flight claim is lost.

## Configuration
- `INTC_EDGE_DET_EN` defined: the trigger is the rising edge of `irq_in[i]`.
  - Detected as `irq_in[i]` & ~`irq_d[i]`, using a per-source delay register that resets to 0.
  - A line held high yields exactly one interrupt.
  - Edges arriving while the source is in PEND or CLAIMED are lost.
- `INTC_EDGE_DET_EN` undefined: the trigger is `irq_in[i]`=1 sampled while IDLE (level mode).
  - A line still high after `complete` re-pends at the next edge.
  - No delay registers are built.

## Structure
- Shared package `intc_pkg` holds:
  - Gateway state encodings `GW_IDLE`, `GW_PEND`, `GW_CLAIMED`.
  - Controller encodings `CTL_READY`, `CTL_BUSY`.
  - Default `NUM_SRC`.
- Sub-module `intc_gateway` contains one source's FSM plus the optional edge detector. It is instantiated `NUM_SRC` times in a generate loop.
- The top level holds the priority encoder, the controller FSM and the `claim_id` register.

## Test plan
- Reset: assert `rst_n`=0 with `irq_in`=8'hFF -> all outputs 0. After release (level mode), `pend_st`=8'hFF and `cpu_irq`=0 while `irq_en`=0.
- Priority: `irq_in`=8'b0010_0100, `irq_en`=8'hFF, `claim_req` -> `claim_id`=2 and `pend_st`=8'b0010_0000. After `complete`, `cpu_irq`=1. A second claim gives `claim_id`=5.
- Mask: source 3 pending with `irq_en[3]`=0 -> `cpu_irq`=0 and `pend_st[3]`=1. Setting `irq_en[3]`=1 gives `cpu_irq`=1 in the same cycle.
- Busy rules: while BUSY, `claim_req` leaves `claim_id` unchanged. `claim_req` together with `complete` -> READY with `claim_vld`=0.
- Level re-trigger (macro off): `irq_in[0]` held high through `complete` -> `pend_st[0]`=1 one edge after `complete`.
- Edge mode (macro on): `irq_in[1]` held high for 10 cycles -> exactly one claim of id 1. A second rising edge after `complete` -> a new pending.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared definitions for the intc_ctrl interrupt controller.
//   - Gateway state encodings (one FSM per interrupt source)
//   - Controller state encodings (claim/complete handshake with the CPU)
//   - Default number of interrupt sources
package intc_pkg;

  localparam int NUM_SRC_DEFAULT = 8;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  typedef enum logic {
    CTL_READY = 1'b0,
    CTL_BUSY  = 1'b1
  } ctl_state_e;

endpackage

// File: rtl/intc_gateway.sv
// Per-source interrupt gateway: IDLE -> PEND on a trigger, PEND -> CLAIMED
// when the source wins a claim, CLAIMED -> IDLE on completion. Triggers seen
// while PEND or CLAIMED are dropped, so a source in service is never
// re-presented.
//
// Configuration macro: INTC_EDGE_DET_EN
//   defined   : trigger is the rising edge of irq_i (delay register built)
//   undefined : trigger is irq_i high while IDLE (level mode)
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   irq_i   - interrupt line from the peripheral
//   grant_i - this source wins the current claim
//   done_i  - CPU completes this source
//   pend_o  - gateway is in PEND
module intc_gateway
  import intc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  input  logic grant_i,
  input  logic done_i,
  output logic pend_o
);

  gw_state_e state_q;
  logic      pend_q;
  logic      trig;

`ifdef INTC_EDGE_DET_EN
  logic irq_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_d_q <= 1'b0;
    else        irq_d_q <= irq_i;
  end

  assign trig = irq_i & ~irq_d_q;
`else
  assign trig = irq_i;
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GW_IDLE;
      pend_q  <= 1'b0;
    end else begin
      unique case (state_q)
        GW_IDLE: if (trig) begin
          state_q <= GW_PEND;
          pend_q  <= 1'b1;
        end
        GW_PEND: if (grant_i) begin
          state_q <= GW_CLAIMED;
          pend_q  <= 1'b0;
        end
        GW_CLAIMED: if (done_i) begin
          state_q <= GW_IDLE;
        end
        default: begin
          state_q <= GW_IDLE;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/intc_ctrl.sv
// Interrupt controller top level. Collects NUM_SRC level interrupt lines
// through per-source gateways, presents a single prioritized request to the
// CPU and runs the claim/complete handshake. Fixed priority: the lowest
// enabled pending index wins. Only one source is in service at a time.
//
// Configuration macro: INTC_EDGE_DET_EN (see intc_gateway) selects edge
// triggering; default build is level triggered.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   irq_in    - interrupt lines, bit i = source i
//   irq_en    - per-source enable mask (masks cpu_irq, not pending)
//   claim_req - CPU claim pulse
//   complete  - CPU completion pulse for the claimed source
//   cpu_irq   - request to the CPU
//   claim_vld - a source is in service and claim_id is valid
//   claim_id  - index of the source in service (holds after complete)
//   pend_st   - per-source pending status
module intc_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               claim_req,
  input  logic               complete,
  output logic               cpu_irq,
  output logic               claim_vld,
  output logic [ID_W-1:0]    claim_id,
  output logic [NUM_SRC-1:0] pend_st
);

  ctl_state_e         ctl_q;
  logic               claim_vld_q;
  logic [ID_W-1:0]    claim_id_q;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] done;
  logic [ID_W-1:0]    win_id;
  logic               take_claim;
  logic               take_done;

  assign req     = pend & irq_en;
  assign cpu_irq = (ctl_q == CTL_READY) && (|req);

  // Scan from the top down so the lowest requesting index is the last write.
  // NOTE: win_id gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) win_id = ID_W'(i);
    end
  end

  assign take_claim = claim_req && cpu_irq;
  // In BUSY a simultaneous claim_req is simply ignored; complete wins.
  assign take_done  = complete && (ctl_q == CTL_BUSY);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign grant[g] = take_claim && (win_id == ID_W'(g));
    assign done[g]  = take_done && (claim_id_q == ID_W'(g));

    intc_gateway u_gw (
      .clk     (clk),
      .rst_n   (rst_n),
      .irq_i   (irq_in[g]),
      .grant_i (grant[g]),
      .done_i  (done[g]),
      .pend_o  (pend[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q       <= CTL_READY;
      claim_vld_q <= 1'b0;
      claim_id_q  <= '0;
    end else begin
      unique case (ctl_q)
        CTL_READY: if (take_claim) begin
          ctl_q       <= CTL_BUSY;
          claim_vld_q <= 1'b1;
          claim_id_q  <= win_id;
        end
        CTL_BUSY: if (take_done) begin
          ctl_q       <= CTL_READY;
          claim_vld_q <= 1'b0;
        end
        default: begin
          ctl_q       <= CTL_READY;
          claim_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign claim_vld = claim_vld_q;
  assign claim_id  = claim_id_q;
  assign pend_st   = pend;

endmodule
